// File: rtl/io_hub.sv
// CPU-bus I/O hub: keyboard FIFO, tick timer, W1C event flags with masked IRQ,
// mouse coordinates, SD command/LBA and video page/border registers.
module io_hub #(
    parameter int unsigned CLK_HZ    = 25_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned KBD_DEPTH = 8,
    parameter logic [15:0] BASE      = 16'h0020
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] a,
    input  logic [7:0]  o,
    input  logic        r,
    input  logic        w,
    output logic [7:0]  p,
    output logic        sd_command,
    output logic        sd_rw,
    output logic [31:0] sd_lba,
    input  logic [1:0]  sd_card,
    input  logic [3:0]  sd_error,
    input  logic        sd_done,
    input  logic        sd_busy,
    output logic        p_vpage,
    output logic [2:0]  p_border,
    input  logic        p_vblank,
    input  logic        p_kdone,
    input  logic [7:0]  p_ascii,
    input  logic [11:0] p_msx,
    input  logic [11:0] p_msy,
    input  logic [2:0]  p_btn,
    input  logic        p_recv,
    output logic        irq
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W = $clog2(KBD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [2:0]       r_border;
    logic             r_vpage;
    logic [31:0]      r_lba;
    logic             r_sd_rw;
    logic             r_sd_cmd;
    logic [5:0]       r_mask;
    logic [5:0]       r_flags;
    logic [7:0]       r_fifo [KBD_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_tick;
    logic             r_irq;

    logic [15:0]      w_off;
    logic             w_hit;
    logic [3:0]       w_sel;
    logic             w_wr;
    logic             w_rd;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf;
    logic             w_tick;
    logic [7:0]       w_flags;
    logic [5:0]       w_set;
    logic [5:0]       w_clr;
    logic [5:0]       w_flags_d;
    logic [CNT_W-1:0] w_count_d;

    // Unsigned subtraction makes addresses below BASE wrap high and miss the window.
    assign w_off = a - BASE;
    assign w_hit = (w_off < 16'd10);
    assign w_sel = w_off[3:0];
    assign w_wr  = w && w_hit;
    assign w_rd  = r && w_hit;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(KBD_DEPTH));
    assign w_pop   = w_rd && (w_sel == 4'd0) && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push  = p_kdone && (!w_full || w_pop);
    assign w_ovf   = p_kdone && w_full && !w_pop;
    assign w_tick  = (r_div == DIV_W'(DIV - 1));

    assign w_flags = {2'b00, r_flags[5:3], !w_empty, r_flags[1:0]};

    always_comb begin
        w_set    = 6'b0;
        w_set[0] = p_vblank;
        w_set[1] = sd_done;
        w_set[3] = p_recv;
        w_set[4] = w_tick;
        w_set[5] = w_ovf;

        w_clr = 6'b0;
        if (w_wr && (w_sel == 4'd3)) begin
            w_clr = o[5:0];
        end
        if (w_rd && (w_sel == 4'd4)) begin
            w_clr[1] = 1'b1;
        end
        if (w_rd && (w_sel == 4'd7)) begin
            w_clr[3] = 1'b1;
        end

        w_flags_d    = (r_flags & ~w_clr) | w_set;
        w_flags_d[2] = 1'b0;
    end

    always_comb begin
        w_count_d = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CNT_W'(1);
            2'b01:   w_count_d = r_count - CNT_W'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_comb begin
        p = 8'h00;
        if (w_hit) begin
            case (w_sel)
                4'd0:    p = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
                4'd1:    p = r_tick;
                4'd2:    p = 8'(r_count);
                4'd3:    p = w_flags;
                4'd4:    p = {sd_busy, w_flags[1], sd_card, sd_error};
                4'd5:    p = p_msx[7:0];
                4'd6:    p = p_msy[7:0];
                4'd7:    p = {w_flags[3], 4'b0000, p_btn};
                4'd8:    p = {p_msy[11:8], p_msx[11:8]};
                4'd9:    p = {2'b00, r_mask};
                default: p = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_border <= 3'b0;
            r_vpage  <= 1'b0;
            r_lba    <= 32'b0;
            r_sd_rw  <= 1'b0;
            r_sd_cmd <= 1'b0;
            r_mask   <= 6'b0;
        end else begin
            r_sd_cmd <= w_wr && (w_sel == 4'd6);
            if (w_wr) begin
                case (w_sel)
                    4'd0:    r_border      <= o[2:0];
                    4'd1:    r_vpage       <= o[0];
                    4'd2:    r_lba[7:0]    <= o;
                    4'd3:    r_lba[15:8]   <= o;
                    4'd4:    r_lba[23:16]  <= o;
                    4'd5:    r_lba[31:24]  <= o;
                    4'd6:    r_sd_rw       <= o[0];
                    4'd9:    r_mask        <= o[5:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_flags  <= 6'b0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_div    <= '0;
            r_tick   <= 8'h00;
            r_irq    <= 1'b0;
        end else begin
            r_flags <= w_flags_d;
            r_count <= w_count_d;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_tick) begin
                r_div  <= '0;
                r_tick <= r_tick + 8'd1;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            r_irq <= |(w_flags[5:0] & r_mask);
        end
    end

    // Storage needs no reset: entries are only visible once counted in.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= p_ascii;
        end
    end

    assign sd_command = r_sd_cmd;
    assign sd_rw      = r_sd_rw;
    assign sd_lba     = r_lba;
    assign p_vpage    = r_vpage;
    assign p_border   = r_border;
    assign irq        = r_irq;

endmodule

// File: tb/tb_io_hub.sv
// Directed bench for io_hub: keyboard bytes go through a scoreboard queue,
// everything else is checked against constants derived from the register map.
module tb_io_hub;

    localparam logic [15:0] BASE_A = 16'h0020;

    logic        clock;
    logic        reset_n;
    logic [15:0] a;
    logic [7:0]  o;
    logic        r;
    logic        w;
    logic [7:0]  p;
    logic        sd_command;
    logic        sd_rw;
    logic [31:0] sd_lba;
    logic [1:0]  sd_card;
    logic [3:0]  sd_error;
    logic        sd_done;
    logic        sd_busy;
    logic        p_vpage;
    logic [2:0]  p_border;
    logic        p_vblank;
    logic        p_kdone;
    logic [7:0]  p_ascii;
    logic [11:0] p_msx;
    logic [11:0] p_msy;
    logic [2:0]  p_btn;
    logic        p_recv;
    logic        irq;

    int          n_vec;
    int          n_err;
    logic [7:0]  exp_q [$];
    int          model_cnt;

    io_hub #(
        .CLK_HZ    (400),
        .TICK_HZ   (100),
        .KBD_DEPTH (8),
        .BASE      (BASE_A)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .a          (a),
        .o          (o),
        .r          (r),
        .w          (w),
        .p          (p),
        .sd_command (sd_command),
        .sd_rw      (sd_rw),
        .sd_lba     (sd_lba),
        .sd_card    (sd_card),
        .sd_error   (sd_error),
        .sd_done    (sd_done),
        .sd_busy    (sd_busy),
        .p_vpage    (p_vpage),
        .p_border   (p_border),
        .p_vblank   (p_vblank),
        .p_kdone    (p_kdone),
        .p_ascii    (p_ascii),
        .p_msx      (p_msx),
        .p_msy      (p_msy),
        .p_btn      (p_btn),
        .p_recv     (p_recv),
        .irq        (irq)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input int off, input logic [7:0] exp, input string tag);
        a = BASE_A + 16'(off);
        #1;
        chk(tag, 32'(p), 32'(exp));
    endtask

    task automatic rdb(input int off, input int b, input logic exp, input string tag);
        a = BASE_A + 16'(off);
        #1;
        chk(tag, 32'(p[b]), 32'(exp));
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        a = BASE_A + 16'(off);
        o = d;
        w = 1'b1;
        step();
        w = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        a = BASE_A;
        r = 1'b1;
        #1;
        chk(tag, 32'(p), 32'(e));
        step();
        r = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_cnt = 0;
        reset_n = 1'b1;
        a = 16'h0000; o = 8'h00; r = 1'b0; w = 1'b0;
        sd_card = 2'b00; sd_error = 4'h0; sd_done = 1'b0; sd_busy = 1'b0;
        p_vblank = 1'b0; p_kdone = 1'b0; p_ascii = 8'h00;
        p_msx = 12'h000; p_msy = 12'h000; p_btn = 3'b000; p_recv = 1'b0;
        #2 reset_n = 1'b0;
        step();
        step();

        // Reset state
        for (int i = 0; i < 10; i++) rd(i, 8'h00, "reset_p");
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_cmd", 32'(sd_command), 32'h0);
        step();

        // Timer with DIV=4
        reset_n = 1'b1;
        repeat (4) step();
        rd(1, 8'h01, "tick_first");
        rdb(3, 4, 1'b1, "tick_flag_set");
        wr(3, 8'h10);
        rdb(3, 4, 1'b0, "tick_flag_w1c");
        repeat (3) step();
        rd(1, 8'h02, "tick_second");
        rdb(3, 4, 1'b1, "tick_flag_again");
        repeat (253 * 4) step();
        rd(1, 8'hFF, "tick_ff");
        repeat (4) step();
        rd(1, 8'h00, "tick_wrap");

        // FIFO fill past depth
        for (int i = 0; i < 9; i++) begin
            p_ascii = 8'h41 + 8'(i);
            p_kdone = 1'b1;
            if (model_cnt < 8) begin
                exp_q.push_back(p_ascii);
                model_cnt++;
            end
            step();
        end
        p_kdone = 1'b0;
        rd(2, 8'h08, "fifo_count_full");
        rdb(3, 5, 1'b1, "fifo_ovf_flag");
        rdb(3, 2, 1'b1, "fifo_key_avail");
        for (int i = 0; i < 8; i++) pop_chk("fifo_pop");
        model_cnt = 0;
        rd(2, 8'h00, "fifo_count_empty");
        rd(0, 8'h00, "fifo_head_empty");
        rdb(3, 2, 1'b0, "fifo_key_none");
        rdb(3, 5, 1'b1, "fifo_ovf_sticky");
        a = BASE_A; r = 1'b1;
        step();
        r = 1'b0;
        rd(2, 8'h00, "fifo_pop_empty");

        // Simultaneous push and pop at count=3
        for (int i = 0; i < 3; i++) begin
            p_ascii = 8'h61 + 8'(i);
            p_kdone = 1'b1;
            exp_q.push_back(p_ascii);
            step();
        end
        p_kdone = 1'b0;
        rd(2, 8'h03, "pp_count_before");
        p_ascii = 8'h64;
        p_kdone = 1'b1;
        exp_q.push_back(p_ascii);
        pop_chk("pp_head");
        p_kdone = 1'b0;
        rd(2, 8'h03, "pp_count_after");
        for (int i = 0; i < 3; i++) pop_chk("pp_order");
        rd(2, 8'h00, "pp_drained");

        // Simultaneous push and pop on an empty FIFO
        p_ascii = 8'h70;
        p_kdone = 1'b1;
        a = BASE_A; r = 1'b1;
        #1;
        chk("pe_head_empty", 32'(p), 32'h00);
        step();
        p_kdone = 1'b0; r = 1'b0;
        exp_q.push_back(8'h70);
        rd(2, 8'h01, "pe_count");
        pop_chk("pe_data");

        // IRQ and W1C
        wr(9, 8'h01);
        rd(9, 8'h01, "mask_rd");
        rdb(3, 0, 1'b0, "vb_clear");
        p_vblank = 1'b1;
        step();
        p_vblank = 1'b0;
        rdb(3, 0, 1'b1, "vb_set");
        chk("irq_latency", 32'(irq), 32'h0);
        step();
        chk("irq_high", 32'(irq), 32'h1);
        wr(3, 8'h01);
        rdb(3, 0, 1'b0, "vb_w1c");
        step();
        chk("irq_low", 32'(irq), 32'h0);
        a = BASE_A + 16'd3; o = 8'h01; w = 1'b1; p_vblank = 1'b1;
        step();
        w = 1'b0; p_vblank = 1'b0;
        rdb(3, 0, 1'b1, "vb_set_wins");

        // SD command and status
        wr(2, 8'h78);
        wr(3, 8'h56);
        wr(4, 8'h34);
        wr(5, 8'h12);
        wr(6, 8'h01);
        chk("sd_cmd_pulse", 32'(sd_command), 32'h1);
        chk("sd_rw", 32'(sd_rw), 32'h1);
        chk("sd_lba", sd_lba, 32'h12345678);
        step();
        chk("sd_cmd_end", 32'(sd_command), 32'h0);
        sd_busy = 1'b1; sd_card = 2'b10; sd_error = 4'h9;
        rd(4, 8'hA9, "sd_status_idle");
        sd_done = 1'b1;
        step();
        sd_done = 1'b0;
        rd(4, 8'hE9, "sd_done_set");
        r = 1'b1;
        step();
        r = 1'b0;
        rd(4, 8'hA9, "sd_done_rdclr");

        // Mouse, window edges, video
        p_msx = 12'hABC; p_msy = 12'h5DE; p_btn = 3'b101;
        rd(5, 8'hBC, "msx_lo");
        rd(6, 8'hDE, "msy_lo");
        rd(8, 8'h5A, "ms_hi");
        rd(7, 8'h05, "btn_idle");
        p_recv = 1'b1;
        step();
        p_recv = 1'b0;
        rd(7, 8'h85, "mouse_flag");
        r = 1'b1;
        step();
        r = 1'b0;
        rd(7, 8'h05, "mouse_rdclr");
        a = 16'h001F; #1; chk("below_window", 32'(p), 32'h00);
        a = 16'h002A; #1; chk("above_window", 32'(p), 32'h00);
        wr(0, 8'hFD);
        chk("border", 32'(p_border), 32'h5);
        wr(1, 8'h01);
        chk("vpage", 32'(p_vpage), 32'h1);

        // Reset mid-sequence cancels a pending command
        p_msx = 12'h000; p_msy = 12'h000; p_btn = 3'b000;
        sd_busy = 1'b0; sd_card = 2'b00; sd_error = 4'h0;
        wr(9, 8'h3F);
        step();
        wr(6, 8'h00);
        chk("pre_reset_cmd", 32'(sd_command), 32'h1);
        chk("pre_reset_irq", 32'(irq), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_cmd", 32'(sd_command), 32'h0);
        chk("mid_reset_irq", 32'(irq), 32'h0);
        chk("mid_reset_lba", sd_lba, 32'h0);
        chk("mid_reset_border", 32'(p_border), 32'h0);
        for (int i = 0; i < 10; i++) rd(i, 8'h00, "mid_reset_p");
        step();
        reset_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
